// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch-side types and constants for the PC sequencer slice.
package rv32i_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_INC   = 32'd4;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/pc_perf_counter.sv
// Wrap-around event counter with an asynchronous active-low clear.
module pc_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch controller: owns the PC, drives a single-outstanding req/ack fetch,
// holds instructions against stall and redirects on execute-stage branches.
module pc_sequencer
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             IMemReq,
    output logic [XLEN-1:0]  IMemAddr,
    input  logic             IMemAck,
    input  logic [XLEN-1:0]  IMemRdata,
    output logic             InstValid,
    output logic [XLEN-1:0]  Inst,
    output logic [XLEN-1:0]  InstPC,
    input  logic             Stall,
    input  logic             ExBranch,
    input  logic             ExTaken,
    input  logic             ExJump,
    input  logic [XLEN-1:0]  ExTarget,
    output logic             Flush,
    output logic             MisalignTrap,
    output logic [CNT_W-1:0] BranchCnt,
    output logic [CNT_W-1:0] TakenCnt
);

    fetch_state_t    state;
    fetch_state_t    next_state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] drain_addr;
    logic            ctrl_flow;
    logic            aligned;
    logic            redir;
    logic            misalign;
    logic            deliver;

    assign ctrl_flow = (ExBranch & ExTaken) | ExJump;
    assign aligned   = (ExTarget[1:0] == 2'b00);
    assign redir     = ctrl_flow & aligned;
    assign misalign  = ctrl_flow & ~aligned;
    assign deliver   = (state == FETCH) & IMemAck & ~redir;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  next_state = FETCH;
            FETCH: begin
                if (redir) begin
                    next_state = IMemAck ? FETCH : DRAIN;
                end else if (IMemAck) begin
                    next_state = Stall ? HOLD : FETCH;
                end
            end
            HOLD: begin
                if (redir || !Stall) begin
                    next_state = FETCH;
                end
            end
            // A redirect without an ack keeps draining; the ack always ends the drain.
            DRAIN: begin
                if (IMemAck) begin
                    next_state = FETCH;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        IMemReq  = 1'b0;
        IMemAddr = pc;
        case (state)
            FETCH: IMemReq = 1'b1;
            DRAIN: begin
                IMemReq  = 1'b1;
                IMemAddr = drain_addr;
            end
            default: IMemReq = 1'b0;
        endcase
    end

    // drain_addr keeps the in-flight address stable after pc jumps to the target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            drain_addr   <= RESET_PC;
            Inst         <= NOP_INST;
            InstPC       <= RESET_PC;
            InstValid    <= 1'b0;
            Flush        <= 1'b0;
            MisalignTrap <= 1'b0;
        end else begin
            Flush        <= redir;
            MisalignTrap <= misalign;
            if ((state == FETCH) && redir && !IMemAck) begin
                drain_addr <= pc;
            end
            if (redir) begin
                pc        <= ExTarget;
                InstValid <= 1'b0;
                Inst      <= NOP_INST;
            end else if (deliver) begin
                Inst      <= IMemRdata;
                InstPC    <= pc;
                InstValid <= 1'b1;
                pc        <= pc + PC_INC;
            end else if ((state != HOLD) || !Stall) begin
                InstValid <= 1'b0;
            end
        end
    end

    pc_perf_counter #(.CNT_W(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ExBranch),
        .count (BranchCnt)
    );

    pc_perf_counter #(.CNT_W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ExBranch & ExTaken),
        .count (TakenCnt)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// traffic against a flag-based behavioural model and a variable-latency memory.
module tb_pc_sequencer;

    localparam int          CW  = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          IMemReq;
    logic [31:0]   IMemAddr;
    logic          IMemAck = 1'b0;
    logic [31:0]   IMemRdata = '0;
    logic          InstValid;
    logic [31:0]   Inst;
    logic [31:0]   InstPC;
    logic          Stall = 1'b0;
    logic          ExBranch = 1'b0;
    logic          ExTaken = 1'b0;
    logic          ExJump = 1'b0;
    logic [31:0]   ExTarget = '0;
    logic          Flush;
    logic          MisalignTrap;
    logic [CW-1:0] BranchCnt;
    logic [CW-1:0] TakenCnt;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .IMemReq      (IMemReq),
        .IMemAddr     (IMemAddr),
        .IMemAck      (IMemAck),
        .IMemRdata    (IMemRdata),
        .InstValid    (InstValid),
        .Inst         (Inst),
        .InstPC       (InstPC),
        .Stall        (Stall),
        .ExBranch     (ExBranch),
        .ExTaken      (ExTaken),
        .ExJump       (ExJump),
        .ExTarget     (ExTarget),
        .Flush        (Flush),
        .MisalignTrap (MisalignTrap),
        .BranchCnt    (BranchCnt),
        .TakenCnt     (TakenCnt)
    );

    int checks = 0;
    int errors = 0;

    // Model: a request is either outstanding (possibly marked for discard) or
    // the sequencer is parked on a held instruction / the post-reset cycle.
    bit          mStarted, mReqOn, mDrop, mValid, mFlush, mTrap;
    logic [31:0] mPc, mReqAddr, mInst, mInstPc;
    int          mBc, mTc;

    int          age = 0;
    int          curWait = 0;
    int          memWait = 0;
    logic [31:0] capAddr = '0;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return a ^ 32'h00A0_0093;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task checkOutput();
        chk("IMemReq", {31'b0, IMemReq}, {31'b0, mReqOn});
        if (mReqOn) chk("IMemAddr", IMemAddr, mReqAddr);
        chk("InstValid", {31'b0, InstValid}, {31'b0, mValid});
        chk("Inst", Inst, mInst);
        chk("InstPC", InstPC, mInstPc);
        chk("Flush", {31'b0, Flush}, {31'b0, mFlush});
        chk("MisalignTrap", {31'b0, MisalignTrap}, {31'b0, mTrap});
        chk("BranchCnt", 32'(BranchCnt), 32'(mBc));
        chk("TakenCnt", 32'(TakenCnt), 32'(mTc));
    endtask

    task modelReset();
        mStarted = 0; mReqOn = 0; mDrop = 0; mValid = 0; mFlush = 0; mTrap = 0;
        mPc = '0; mReqAddr = '0; mInst = NOP; mInstPc = '0; mBc = 0; mTc = 0;
    endtask

    task startReq();
        mReqOn   = 1;
        mReqAddr = mPc;
    endtask

    task modelStep(input bit ack, input logic [31:0] rdata, input bit stl,
                   input bit b, input bit t, input bit j, input logic [31:0] tgt);
        bit want, redir;
        want   = (b && t) || j;
        redir  = want && (tgt[1:0] == 2'b00);
        mFlush = redir;
        mTrap  = want && !redir;
        mBc    = (mBc + int'(b)) % (1 << CW);
        mTc    = (mTc + int'(b && t)) % (1 << CW);
        if (!mStarted) begin
            mStarted = 1;
            if (redir) begin mPc = tgt; mValid = 0; mInst = NOP; end
            startReq();
        end else if (mReqOn) begin
            if (ack) begin
                if (redir) begin
                    mPc = tgt; mValid = 0; mInst = NOP; mDrop = 0; startReq();
                end else if (mDrop) begin
                    mDrop = 0; mValid = 0; startReq();
                end else begin
                    mInst = rdata; mInstPc = mPc; mValid = 1; mPc = mPc + 32'd4;
                    if (stl) mReqOn = 0;
                    else     startReq();
                end
            end else if (redir) begin
                mDrop = 1; mPc = tgt; mValid = 0; mInst = NOP;
            end else begin
                mValid = 0;
            end
        end else begin
            if (redir) begin
                mPc = tgt; mValid = 0; mInst = NOP; startReq();
            end else if (!stl) begin
                mValid = 0; startReq();
            end
        end
    endtask

    // One clock: memory response, input drive and model update at negedge,
    // then compare after the rising edge.
    task applyStimulus(input bit rstV, input bit stallV, input bit bV, input bit tV,
                       input bit jV, input logic [31:0] tgtV, input bit spur);
        logic        ackN;
        logic [31:0] rdN;
        @(negedge clk);
        ackN = 1'b0;
        rdN  = 32'hDEAD_BEEF;
        if (rstV) begin
            age = 0;
        end else begin
            if (IMemAck) age = 0;
            if (IMemReq) begin
                age++;
                if (age == 1) begin
                    capAddr = IMemAddr;
                    curWait = (memWait < 0) ? int'($urandom_range(0, 3)) : memWait;
                end
                ackN = (age >= 2 + curWait);
                rdN  = memword(capAddr);
            end else begin
                age = 0;
                if (spur) ackN = 1'b1;
            end
        end
        rst_n     = !rstV;
        IMemAck   = ackN;
        IMemRdata = rdN;
        Stall     = stallV;
        ExBranch  = bV;
        ExTaken   = tV;
        ExJump    = jV;
        ExTarget  = tgtV;
        if (rstV) modelReset();
        else      modelStep(ackN, rdN, stallV, bV, tV, jV, tgtV);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task idleCycle();
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 0);
    endtask

    initial begin
        bit rs, st, b, t, j;
        logic [31:0] tg;
        modelReset();
        $display("[TB] start");

        applyStimulus(1, 0, 0, 0, 0, 32'h0, 0);
        applyStimulus(1, 0, 0, 0, 0, 32'h0, 0);
        chk("rst_IMemReq", {31'b0, IMemReq}, 32'd0);
        chk("rst_Inst", Inst, 32'h0000_0013);
        chk("rst_InstPC", InstPC, 32'h0);
        chk("rst_BranchCnt", 32'(BranchCnt), 32'd0);

        memWait = 0;
        applyStimulus(0, 0, 0, 0, 0, 32'h0, 1);
        chk("first_req", {31'b0, IMemReq}, 32'd1);
        chk("first_addr", IMemAddr, 32'h0);
        idleCycle();
        idleCycle();
        chk("first_valid", {31'b0, InstValid}, 32'd1);
        chk("first_inst", Inst, 32'h00A0_0093);
        chk("first_instpc", InstPC, 32'h0);
        chk("next_addr", IMemAddr, 32'h4);

        idleCycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 0, 0, 32'h0, 0);
            chk("stall_req", {31'b0, IMemReq}, 32'd0);
            chk("stall_instpc", InstPC, 32'h4);
            chk("stall_valid", {31'b0, InstValid}, 32'd1);
        end
        idleCycle();
        chk("post_stall_addr", IMemAddr, 32'h8);

        idleCycle();
        idleCycle();
        memWait = 3;
        applyStimulus(0, 0, 1, 1, 0, 32'h100, 0);
        chk("br_flush", {31'b0, Flush}, 32'd1);
        chk("br_drain_addr", IMemAddr, 32'hC);
        for (int i = 0; i < 3; i++) begin
            idleCycle();
            chk("drain_addr_hold", IMemAddr, 32'hC);
            chk("drain_flush_low", {31'b0, Flush}, 32'd0);
        end
        idleCycle();
        chk("drain_valid", {31'b0, InstValid}, 32'd0);
        chk("drain_target", IMemAddr, 32'h100);

        memWait = 0;
        idleCycle();
        applyStimulus(0, 0, 0, 0, 1, 32'h200, 0);
        chk("coinc_valid", {31'b0, InstValid}, 32'd0);
        chk("coinc_addr", IMemAddr, 32'h200);

        applyStimulus(0, 0, 0, 0, 1, 32'h102, 0);
        chk("mis_trap", {31'b0, MisalignTrap}, 32'd1);
        chk("mis_flush", {31'b0, Flush}, 32'd0);
        chk("mis_addr", IMemAddr, 32'h200);
        idleCycle();
        chk("mis_trap_low", {31'b0, MisalignTrap}, 32'd0);
        chk("mis_seq_addr", IMemAddr, 32'h204);

        applyStimulus(1, 0, 0, 0, 0, 32'h0, 0);
        for (int i = 0; i < 10; i++)
            applyStimulus(0, 0, 1, (i % 3 == 0), 0, 32'h1, 0);
        chk("cnt_branch10", 32'(BranchCnt), 32'd10);
        chk("cnt_taken4", 32'(TakenCnt), 32'd4);
        for (int i = 0; i < 6; i++)
            applyStimulus(0, 0, 1, 0, 0, 32'h0, 0);
        chk("cnt_wrap", 32'(BranchCnt), 32'd0);
        chk("cnt_taken_hold", 32'(TakenCnt), 32'd4);

        memWait = -1;
        for (int n = 0; n < 3000; n++) begin
            rs = ($urandom_range(0, 399) == 0);
            st = ($urandom_range(0, 9) < 3);
            b  = ($urandom_range(0, 4) == 0);
            t  = $urandom_range(0, 1) == 1;
            j  = ($urandom_range(0, 9) == 0);
            tg = $urandom & 32'h0000_0FFC;
            if ($urandom_range(0, 6) == 0) tg[1:0] = 2'($urandom_range(1, 3));
            applyStimulus(rs, st, b, t, j, tg, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
